cga_vidout_sel: RTL and testbench

//  Parametrised analog/digital video output selector between the CGA core and the board pins.

---
 rtl/cga_vidout_sel_pkg.sv | 25 ++
 rtl/cga_sw_debounce.sv | 43 ++++
 rtl/cga_vidout_sel.sv | 126 ++++++++++++
 tb/tb_cga_vidout_sel.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cga_vidout_sel_pkg.sv
// Shared widths, debounce limits and mode types for the CGA video output selector.
package cga_vidout_sel_pkg;

    localparam int DEF_RED_W = 6;
    localparam int DEF_GRN_W = 7;
    localparam int DEF_BLU_W = 6;

    // 10 ms at the 28.636 MHz pixel clock; the short value keeps simulations fast.
    localparam int DEBOUNCE_MAX_HW  = 286363;
    localparam int DEBOUNCE_MAX_SIM = 10;

    localparam int SW_COMP = 0;
    localparam int SW_THIN = 1;
    localparam int SW_NUM  = 2;

    typedef struct packed {
        logic thin;
        logic comp;
    } mode_t;

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/cga_sw_debounce.sv
// Two-flop synchroniser followed by a stability counter for one slow config switch.
module cga_sw_debounce
    import cga_vidout_sel_pkg::*;
#(
    parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_SIM
) (
    input  logic clk,
    input  logic srst,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = cnt_width(DEBOUNCE_MAX);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            // Any return to the accepted level restarts the count from zero.
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_MAX)) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/cga_vidout_sel.sv
// Registered RGB/composite output mux with debounced mode switches applied only on vsync rise.
module cga_vidout_sel
    import cga_vidout_sel_pkg::*;
#(
    parameter int RED_W        = DEF_RED_W,
    parameter int GRN_W        = DEF_GRN_W,
    parameter int BLU_W        = DEF_BLU_W,
    parameter int DEBOUNCE_MAX = DEBOUNCE_MAX_HW,
    parameter int PIPE_DEPTH   = 2,
    parameter bit BLANK_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             busreset,
    input  logic             sw_comp_raw,
    input  logic             sw_thin_raw,
    input  logic [RED_W-1:0] vga_red,
    input  logic [GRN_W-1:0] vga_green,
    input  logic [BLU_W-1:0] vga_blue,
    input  logic [GRN_W-1:0] comp_video,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    output logic [RED_W-1:0] red,
    output logic [GRN_W-1:0] green,
    output logic [BLU_W-1:0] blue,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             composite_on,
    output logic             thin_font,
    output logic             mode_change
);

    localparam int W_TOT = RED_W + GRN_W + BLU_W + 3;

    logic [SW_NUM-1:0] sw_raw;
    logic [SW_NUM-1:0] sw_stable;

    assign sw_raw[SW_COMP] = sw_comp_raw;
    assign sw_raw[SW_THIN] = sw_thin_raw;

    for (genvar gi = 0; gi < SW_NUM; gi++) begin : g_sw
        cga_sw_debounce #(
            .DEBOUNCE_MAX (DEBOUNCE_MAX)
        ) u_debounce (
            .clk    (clk),
            .srst   (busreset),
            .raw    (sw_raw[gi]),
            .stable (sw_stable[gi])
        );
    end

    logic  vsync_q_reg;
    logic  vs_edge;
    mode_t mode_reg;
    mode_t mode_next;
    logic  mode_change_reg;

    assign vs_edge = vsync_in & ~vsync_q_reg;

    always_comb begin
        mode_next      = '0;
        mode_next.comp = sw_stable[SW_COMP];
        mode_next.thin = sw_stable[SW_THIN];
    end

    // Modes only move at the start of vertical sync so a frame is never split between modes.
    always_ff @(posedge clk) begin
        if (busreset) begin
            vsync_q_reg     <= 1'b0;
            mode_reg        <= '0;
            mode_change_reg <= 1'b0;
        end else begin
            vsync_q_reg     <= vsync_in;
            mode_change_reg <= 1'b0;
            if (vs_edge) begin
                mode_reg        <= mode_next;
                mode_change_reg <= (mode_next != mode_reg);
            end
        end
    end

    logic             blank;
    logic [RED_W-1:0] red_next;
    logic [GRN_W-1:0] green_next;
    logic [BLU_W-1:0] blue_next;

    always_comb begin
        blank      = BLANK_EN && !de_in;
        red_next   = '0;
        green_next = '0;
        blue_next  = '0;
        if (!blank) begin
            if (mode_reg.comp) begin
                green_next = comp_video;
            end else begin
                red_next   = vga_red;
                green_next = vga_green;
                blue_next  = vga_blue;
            end
        end
    end

    // Video and timing travel in one word so every stage keeps them aligned.
    logic [W_TOT-1:0]                  stage_next;
    logic [PIPE_DEPTH-1:0][W_TOT-1:0]  pipe_reg;

    assign stage_next = {red_next, green_next, blue_next, hsync_in, vsync_in, de_in};

    always_ff @(posedge clk) begin
        if (busreset) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg[0] <= stage_next;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    assign {red, green, blue, hsync, vsync, de} = pipe_reg[PIPE_DEPTH-1];
    assign composite_on = mode_reg.comp;
    assign thin_font    = mode_reg.thin;
    assign mode_change  = mode_change_reg;

endmodule

// File: tb/tb_cga_vidout_sel.sv
// Randomised and directed checks of cga_vidout_sel against a frame-level behavioural model.
module tb_cga_vidout_sel;

    localparam int RW = 6;
    localparam int GW = 7;
    localparam int BW = 6;
    localparam int DMAX = 10;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          busreset;
    logic          sw_comp_raw, sw_thin_raw;
    logic [RW-1:0] vga_red;
    logic [GW-1:0] vga_green;
    logic [BW-1:0] vga_blue;
    logic [GW-1:0] comp_video;
    logic          hsync_in, vsync_in, de_in;
    logic [RW-1:0] red;
    logic [GW-1:0] green;
    logic [BW-1:0] blue;
    logic          hsync, vsync, de;
    logic          composite_on, thin_font, mode_change;

    int checks   = 0;
    int failures = 0;
    int mc_seen  = 0;

    always #5 clk = ~clk;

    cga_vidout_sel #(
        .RED_W        (RW),
        .GRN_W        (GW),
        .BLU_W        (BW),
        .DEBOUNCE_MAX (DMAX),
        .PIPE_DEPTH   (DEPTH),
        .BLANK_EN     (1'b1)
    ) dut (
        .clk          (clk),
        .busreset     (busreset),
        .sw_comp_raw  (sw_comp_raw),
        .sw_thin_raw  (sw_thin_raw),
        .vga_red      (vga_red),
        .vga_green    (vga_green),
        .vga_blue     (vga_blue),
        .comp_video   (comp_video),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .de_in        (de_in),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .composite_on (composite_on),
        .thin_font    (thin_font),
        .mode_change  (mode_change)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what a pixel must look like, and when switches are allowed to take effect.
    typedef struct packed {
        logic [RW-1:0] r;
        logic [GW-1:0] g;
        logic [BW-1:0] b;
        logic          hs;
        logic          vs;
        logic          de;
    } frame_t;

    frame_t m_q[$];
    bit     m_valid = 0;
    bit     m_dly1[2], m_dly2[2], m_acc[2], m_acc_old[2];
    int     m_disagree[2];
    bit     m_prev_vs, m_comp, m_thin, m_mc;
    bit     raw_now[2];

    initial forever begin
        @(posedge clk);
        if (busreset) begin
            m_valid = 1;
            for (int i = 0; i < 2; i++) begin
                m_dly1[i] = 0; m_dly2[i] = 0; m_acc[i] = 0; m_disagree[i] = 0;
            end
            m_prev_vs = 0; m_comp = 0; m_thin = 0; m_mc = 0;
            m_q.delete();
            for (int i = 0; i < DEPTH; i++) m_q.push_front('0);
        end else if (m_valid) begin
            frame_t f;
            bit blank;
            bit vs_rise;
            raw_now[0] = sw_comp_raw;
            raw_now[1] = sw_thin_raw;
            blank = !de_in;
            f = '0;
            f.hs = hsync_in; f.vs = vsync_in; f.de = de_in;
            if (!blank) begin
                if (m_comp) f.g = comp_video;
                else begin f.r = vga_red; f.g = vga_green; f.b = vga_blue; end
            end
            m_q.push_front(f);
            if (m_q.size() > DEPTH) void'(m_q.pop_back());
            // A switch is accepted after disagreeing with the accepted level for more than DMAX clocks.
            for (int i = 0; i < 2; i++) begin
                m_acc_old[i] = m_acc[i];
                if (m_dly2[i] == m_acc[i]) m_disagree[i] = 0;
                else begin
                    m_disagree[i]++;
                    if (m_disagree[i] > DMAX) begin
                        m_acc[i] = m_dly2[i];
                        m_disagree[i] = 0;
                    end
                end
                m_dly2[i] = m_dly1[i];
                m_dly1[i] = raw_now[i];
            end
            vs_rise = vsync_in && !m_prev_vs;
            m_prev_vs = vsync_in;
            m_mc = 0;
            if (vs_rise) begin
                m_mc = (m_acc_old[0] != m_comp) || (m_acc_old[1] != m_thin);
                m_comp = m_acc_old[0];
                m_thin = m_acc_old[1];
            end
        end
        #1;
        if (m_valid) begin
            frame_t e;
            e = m_q[DEPTH-1];
            if (mode_change === 1'b1) mc_seen++;
            check("red", red, e.r);
            check("green", green, e.g);
            check("blue", blue, e.b);
            check("hsync", hsync, e.hs);
            check("vsync", vsync, e.vs);
            check("de", de, e.de);
            check("composite_on", composite_on, m_comp);
            check("thin_font", thin_font, m_thin);
            check("mode_change", mode_change, m_mc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        busreset = 1; sw_comp_raw = 0; sw_thin_raw = 0;
        vga_red = '0; vga_green = '0; vga_blue = '0; comp_video = '0;
        hsync_in = 0; vsync_in = 0; de_in = 0;
        tick(2);
        check("reset_outputs", {red, green, blue, hsync, vsync, de, composite_on, thin_font, mode_change}, 0);

        busreset = 0; vga_red = 6'h15; de_in = 1;
        tick(1);
        check("red_after_1clk", red, 0);
        tick(1);
        check("red_after_2clk", red, 6'h15);

        // Short glitch must never reach the applied mode.
        mc_seen = 0;
        sw_comp_raw = 1; tick(5); sw_comp_raw = 0; tick(20);
        vsync_in = 1; tick(3); vsync_in = 0; tick(3);
        check("glitch_composite", composite_on, 0);
        check("glitch_mode_change", mc_seen, 0);

        sw_comp_raw = 1; tick(20);
        vsync_in = 1; tick(1);
        check("debounce_composite", composite_on, 1);
        check("debounce_mode_change", mode_change, 1);
        tick(1);
        check("mode_change_pulse_end", mode_change, 0);
        vsync_in = 0;
        comp_video = 7'h5A; vga_red = 6'h2A; vga_green = 7'h33; vga_blue = 6'h11; de_in = 1;
        tick(2);
        check("comp_green", green, 7'h5A);
        check("comp_red", red, 0);
        check("comp_blue", blue, 0);

        de_in = 0; vga_green = 7'h7F; comp_video = 7'h7F; hsync_in = 1;
        tick(2);
        check("blank_green", green, 0);
        check("blank_de", de, 0);
        check("blank_hsync", hsync, 1);
        hsync_in = 0; de_in = 1;

        sw_thin_raw = 1; tick(20);
        check("midframe_thin_held", thin_font, 0);
        vsync_in = 1; tick(1);
        check("vsync_thin_applied", thin_font, 1);
        check("vsync_thin_mode_change", mode_change, 1);
        vsync_in = 0; tick(2);

        // Reset part-way through a debounce count must restart it from scratch.
        sw_comp_raw = 0; sw_thin_raw = 0; busreset = 1; tick(1);
        busreset = 0; sw_comp_raw = 1; tick(9);
        busreset = 1; tick(1);
        busreset = 0; tick(9);
        vsync_in = 1; tick(1);
        check("rst_debounce_not_done", composite_on, 0);
        vsync_in = 0; tick(10);
        vsync_in = 1; tick(1);
        check("rst_debounce_done", composite_on, 1);
        vsync_in = 0; tick(1);

        for (int c = 0; c < 3000; c++) begin
            vga_red    = RW'($urandom);
            vga_green  = GW'($urandom);
            vga_blue   = BW'($urandom);
            comp_video = GW'($urandom);
            hsync_in   = 1'($urandom);
            de_in      = ($urandom_range(3, 0) != 0);
            if ($urandom_range(39, 0) == 0) sw_comp_raw = ~sw_comp_raw;
            if ($urandom_range(39, 0) == 0) sw_thin_raw = ~sw_thin_raw;
            if ($urandom_range(24, 0) == 0) vsync_in = ~vsync_in;
            busreset = ($urandom_range(499, 0) == 0);
            tick(1);
        end
        busreset = 0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
